// File: rtl/paddle_control_gen_pkg.sv
// Shared command codes and direction-state encoding for the paddle control path.
// The paddle position block imports the same CTRL_* constants.
package paddle_control_gen_pkg;

  localparam logic [1:0] CTRL_NONE  = 2'd0;
  localparam logic [1:0] CTRL_LEFT  = 2'd1;
  localparam logic [1:0] CTRL_RIGHT = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLeft  = 2'd1,
    StRight = 2'd2
  } dir_state_e;

  function automatic logic [1:0] dir_code(input dir_state_e st);
    logic [1:0] code;
    case (st)
      StLeft:  code = CTRL_LEFT;
      StRight: code = CTRL_RIGHT;
      default: code = CTRL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/paddle_control_gen_if.sv
// Player/tracking inputs and paddle command outputs of the paddle control generator.
interface paddle_control_gen_if;

  logic       btn_left;
  logic       btn_right;
  logic       auto_mode;
  logic [9:0] ball_x;
  logic [9:0] paddle_x;
  logic [1:0] controls;
  logic [1:0] btn_state;
  logic       move_tick;

  modport master (
    output btn_left,
    output btn_right,
    output auto_mode,
    output ball_x,
    output paddle_x,
    input  controls,
    input  btn_state,
    input  move_tick
  );

  modport slave (
    input  btn_left,
    input  btn_right,
    input  auto_mode,
    input  ball_x,
    input  paddle_x,
    output controls,
    output btn_state,
    output move_tick
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a level debouncer: a new level is accepted only
// after it has been seen unchanged for DB_LIMIT consecutive clocks.
module button_debounce #(
  parameter int unsigned DB_LIMIT = 250000,
  parameter int unsigned DB_BITS  = 18
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam logic [DB_BITS-1:0] CntLast = DB_BITS'(DB_LIMIT - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [DB_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any return to the accepted level throws away the partial count.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + DB_BITS'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/paddle_control_gen.sv
// Generates rate-limited paddle move commands from debounced buttons or ball tracking;
// controls is non-zero for one clock per movement tick.
module paddle_control_gen
  import paddle_control_gen_pkg::*;
#(
  parameter int unsigned DB_LIMIT = 250000,
  parameter int unsigned DB_BITS  = 18,
  parameter int unsigned MOVE_DIV = 100000,
  parameter int unsigned DIV_BITS = 17,
  parameter int unsigned DEADZONE = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  paddle_control_gen_if.slave  io_bus
);

  localparam logic [DIV_BITS-1:0] DivLast = DIV_BITS'(MOVE_DIV - 1);
  localparam logic [10:0]         DzExt   = 11'(DEADZONE);

  logic                w_db_left;
  logic                w_db_right;
  logic                w_tick;
  logic [10:0]         w_ball_ext;
  logic [10:0]         w_paddle_ext;
  logic [10:0]         w_ball_plus;
  logic [10:0]         w_paddle_plus;
  dir_state_e          w_next_state;

  logic [DIV_BITS-1:0] r_div;
  dir_state_e          r_state;
  logic [1:0]          r_controls;
  logic                r_move_tick;

  button_debounce #(
    .DB_LIMIT (DB_LIMIT),
    .DB_BITS  (DB_BITS)
  ) u_db_left (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_raw    (io_bus.btn_left),
    .o_stable (w_db_left)
  );

  button_debounce #(
    .DB_LIMIT (DB_LIMIT),
    .DB_BITS  (DB_BITS)
  ) u_db_right (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_raw    (io_bus.btn_right),
    .o_stable (w_db_right)
  );

  assign w_tick = (r_div == DivLast);

  // Free-running: ticks are not realigned by mode or button changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_BITS'(1);
    end
  end

  // One extra bit keeps the dead-zone sums from wrapping near either screen edge.
  assign w_ball_ext    = {1'b0, io_bus.ball_x};
  assign w_paddle_ext  = {1'b0, io_bus.paddle_x};
  assign w_ball_plus   = w_ball_ext + DzExt;
  assign w_paddle_plus = w_paddle_ext + DzExt;

  always_comb begin
    w_next_state = r_state;
    if (io_bus.auto_mode) begin
      if (w_ball_plus < w_paddle_ext) begin
        w_next_state = StLeft;
      end else if (w_ball_ext > w_paddle_plus) begin
        w_next_state = StRight;
      end else begin
        w_next_state = StIdle;
      end
    end else begin
      case ({w_db_right, w_db_left})
        2'b01:   w_next_state = StLeft;
        2'b10:   w_next_state = StRight;
        2'b00:   w_next_state = StIdle;
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_controls  <= CTRL_NONE;
      r_move_tick <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_move_tick <= w_tick;
      r_controls  <= w_tick ? dir_code(w_next_state) : CTRL_NONE;
    end
  end

  assign io_bus.controls  = r_controls;
  assign io_bus.btn_state = {w_db_right, w_db_left};
  assign io_bus.move_tick = r_move_tick;

endmodule

// File: tb/tb_paddle_control_gen.sv
// Directed and random checks of paddle_control_gen against a cycle model with a
// scoreboard queue, using small debounce and divider constants.
module tb_paddle_control_gen;

  localparam int unsigned DB_LIMIT = 4;
  localparam int unsigned DB_BITS  = 3;
  localparam int unsigned MOVE_DIV = 8;
  localparam int unsigned DIV_BITS = 4;
  localparam int unsigned DEADZONE = 4;

  typedef struct packed {
    logic [1:0] controls;
    logic [1:0] btn_state;
    logic       move_tick;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  exp_t sb_q[$];

  // Bench model state
  logic [1:0] m_s1;
  logic [1:0] m_s2;
  logic [1:0] m_stable;
  int         m_cnt[2];
  int         m_div;
  int         m_dir;

  paddle_control_gen_if u_if ();

  paddle_control_gen #(
    .DB_LIMIT (DB_LIMIT),
    .DB_BITS  (DB_BITS),
    .MOVE_DIV (MOVE_DIV),
    .DIV_BITS (DIV_BITS),
    .DEADZONE (DEADZONE)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs of the coming edge, advance one clock, then score the DUT.
  task automatic step();
    exp_t e;
    int   nxt;
    int   bx;
    int   px;
    logic tick;
    e = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_div = 0; m_dir = 0;
    end else begin
      tick = (m_div == MOVE_DIV - 1);
      if (u_if.auto_mode) begin
        bx = int'(u_if.ball_x);
        px = int'(u_if.paddle_x);
        if (bx + DEADZONE < px) nxt = 1;
        else if (bx > px + DEADZONE) nxt = 2;
        else nxt = 0;
      end else begin
        case (m_stable)
          2'b01:   nxt = 1;
          2'b10:   nxt = 2;
          2'b00:   nxt = 0;
          default: nxt = m_dir;
        endcase
      end
      m_dir = nxt;
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] == m_stable[b]) m_cnt[b] = 0;
        else if (m_cnt[b] == DB_LIMIT - 1) begin
          m_stable[b] = m_s2[b];
          m_cnt[b] = 0;
        end else m_cnt[b] = m_cnt[b] + 1;
      end
      m_s2 = m_s1;
      m_s1 = {u_if.btn_right, u_if.btn_left};
      m_div = (m_div + 1) % MOVE_DIV;
      e.controls  = tick ? 2'(nxt) : 2'd0;
      e.move_tick = tick;
    end
    e.btn_state = m_stable;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(32'(u_if.controls), 32'(e.controls), "controls");
    check(32'(u_if.btn_state), 32'(e.btn_state), "btn_state");
    check(32'(u_if.move_tick), 32'(e.move_tick), "move_tick");
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_on_tick(input logic [1:0] exp, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (u_if.move_tick !== 1'b1 && n < 2 * MOVE_DIV);
    check(32'(u_if.move_tick), 32'd1, {tag, "_tick_seen"});
    check(32'(u_if.controls), 32'(exp), tag);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    u_if.btn_left  = 1'b0;
    u_if.btn_right = 1'b0;
    u_if.auto_mode = 1'b0;
    u_if.ball_x    = 10'd0;
    u_if.paddle_x  = 10'd0;
    #1;
    steps(2);
    check(32'(u_if.controls), 32'd0, "reset_controls");
    check(32'(u_if.btn_state), 32'd0, "reset_btn_state");
    check(32'(u_if.move_tick), 32'd0, "reset_move_tick");
    rst = 1'b0;

    // 1: steady left press is accepted six clocks after the raw edge
    u_if.btn_left = 1'b1;
    steps(5);
    check(32'(u_if.btn_state), 32'h0, "t1_btn_before");
    step();
    check(32'(u_if.btn_state), 32'h1, "t1_btn_accepted");
    expect_on_tick(2'd1, "t1_left_tick_a");
    expect_on_tick(2'd1, "t1_left_tick_b");

    // 2: bouncing right button is ignored until it settles
    u_if.btn_left = 1'b0;
    steps(8);
    for (int i = 0; i < 20; i++) begin
      u_if.btn_right = ((i % 4) < 2);
      step();
      check(32'(u_if.btn_state[1]), 32'd0, "t2_bounce_ignored");
    end
    u_if.btn_right = 1'b1;
    steps(5);
    check(32'(u_if.btn_state[1]), 32'd0, "t2_right_before");
    step();
    check(32'(u_if.btn_state[1]), 32'd1, "t2_right_accepted");
    expect_on_tick(2'd2, "t2_right_tick");

    // 3: both pressed holds LEFT; releasing left switches to RIGHT
    u_if.btn_right = 1'b0;
    u_if.btn_left  = 1'b1;
    steps(8);
    expect_on_tick(2'd1, "t3_left");
    u_if.btn_right = 1'b1;
    steps(8);
    expect_on_tick(2'd1, "t3_both_hold_a");
    expect_on_tick(2'd1, "t3_both_hold_b");
    u_if.btn_left = 1'b0;
    steps(6);
    expect_on_tick(2'd2, "t3_release_left");

    // 4: auto tracking around the dead zone
    u_if.auto_mode = 1'b1;
    u_if.paddle_x  = 10'd300;
    u_if.ball_x    = 10'd295; expect_on_tick(2'd1, "t4_ball295");
    u_if.ball_x    = 10'd296; expect_on_tick(2'd0, "t4_ball296");
    u_if.ball_x    = 10'd304; expect_on_tick(2'd0, "t4_ball304");
    u_if.ball_x    = 10'd305; expect_on_tick(2'd2, "t4_ball305");
    u_if.ball_x    = 10'd0;
    u_if.paddle_x  = 10'd3;   expect_on_tick(2'd0, "t4_no_underflow");
    u_if.ball_x    = 10'd1023;
    u_if.paddle_x  = 10'd0;   expect_on_tick(2'd2, "t4_far_right");
    u_if.ball_x    = 10'd0;
    u_if.paddle_x  = 10'd1023; expect_on_tick(2'd1, "t4_far_left");

    // 5: reset mid-debounce discards progress and realigns the divider
    u_if.auto_mode = 1'b0;
    u_if.btn_left  = 1'b0;
    u_if.btn_right = 1'b0;
    steps(10);
    u_if.btn_right = 1'b1;
    steps(4);
    rst = 1'b1;
    step();
    check(32'(u_if.btn_state), 32'd0, "t5_rst_btn");
    check(32'(u_if.controls), 32'd0, "t5_rst_ctrl");
    check(32'(u_if.move_tick), 32'd0, "t5_rst_tick");
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 5) check(32'(u_if.btn_state), 32'h0, "t5_restart_before");
      if (i == 6) check(32'(u_if.btn_state), 32'h2, "t5_restart_accept");
      if (i < 8) check(32'(u_if.move_tick), 32'd0, "t5_no_early_tick");
      else check(32'(u_if.move_tick), 32'd1, "t5_first_tick");
    end

    // 6: random stimulus with output invariants
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) u_if.btn_left = ~u_if.btn_left;
      if ($urandom_range(7) == 0) u_if.btn_right = ~u_if.btn_right;
      if ($urandom_range(199) == 0) u_if.auto_mode = ~u_if.auto_mode;
      if ((i % 16) == 0) begin
        u_if.ball_x   = 10'($urandom_range(1023));
        u_if.paddle_x = 10'($urandom_range(1023));
      end
      step();
      check(32'(u_if.controls == 2'd3), 32'd0, "t6_never_3");
      check(32'(u_if.controls != 2'd0 && u_if.move_tick !== 1'b1), 32'd0, "t6_ctrl_only_on_tick");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_control_gen.md
Name: paddle_control_gen

Overview:
- Produces the 2-bit `controls` command consumed by the paddle position block: 0 = hold, 1 = left, 2 = right.
- Manual mode: command comes from raw player push-buttons, which are synchronized and debounced here.
- Auto mode: command comes from ball-tracking logic.
- Movement is rate-limited. `controls` is non-zero for exactly one clock per movement tick, so one paddle step happens per tick.

Parameters:
- DB_LIMIT, 250000: clocks a synced button level must stay unchanged before it is accepted (10 ms at 25 MHz).
- DB_BITS, 18: debounce counter width; must satisfy 2^DB_BITS > DB_LIMIT.
- MOVE_DIV, 100000: clocks per movement tick (250 steps/s at 25 MHz).
- DIV_BITS, 17: tick counter width; must satisfy 2^DIV_BITS > MOVE_DIV.
- DEADZONE, 4: auto-mode tolerance in pixels between ball_x and paddle_x.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_left  in  1  raw left push-button, asynchronous, active-high.
- btn_right  in  1  raw right push-button, asynchronous, active-high.
- auto_mode  in  1  1 = ball tracking, 0 = buttons.
- ball_x  in  10  ball centre x, pixels.
- paddle_x  in  10  current paddle centre x, fed back from the paddle block.
- controls  out  2  registered command: 0 none, 1 left, 2 right; 3 is never driven.
- btn_state  out  2  debounced levels, {right, left}.
- move_tick  out  1  registered one-clock pulse at each movement tick.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - controls=0, btn_state=0, move_tick=0.
  - Sync flops, debounce counters and tick counter = 0.
  - FSM = IDLE.
  - Reset mid-debounce or mid-tick discards all progress.
- Synchronizer: 2-flop chain per button; the second flop is `s`.
- Debounce, per button:
  - If s == stable: cnt <= 0.
  - Else if cnt == DB_LIMIT-1: stable <= s and cnt <= 0.
  - Else cnt <= cnt+1.
  - A press therefore appears on btn_state 2 + DB_LIMIT clocks after the raw edge, provided the raw level does not change in that window.
  - Any bounce back to the old level restarts the count.
- Tick divider:
  - div counts 0..MOVE_DIV-1 and wraps to 0.
  - tick = (div == MOVE_DIV-1); move_tick <= tick.
  - The divider runs freely, independent of mode and buttons.
- Direction FSM, states IDLE / LEFT / RIGHT, updated every clock.
- Manual mode (auto_mode=0), from debounced levels:
  - left only → LEFT.
  - right only → RIGHT.
  - neither → IDLE.
  - both → hold current state (IDLE stays IDLE).
- Auto mode (auto_mode=1), all compares in 11-bit unsigned, no wrap:
  - ball_x + DEADZONE < paddle_x → LEFT.
  - ball_x > paddle_x + DEADZONE → RIGHT.
  - otherwise → IDLE.
  - Equality at the dead-zone edge → IDLE.
- Output register: controls <= tick ? code(next state) : 0, where IDLE=0, LEFT=1, RIGHT=2.
  - Latency: the command is visible the clock after tick, coincident with move_tick.
  - controls is 0 on every clock where move_tick = 0.
- Mode switch: takes effect on the next FSM update. Debouncers keep running in auto mode, so btn_state stays valid.
- Wall limits are not enforced here; the paddle block clamps.

Decomposition:
- Shared package:
  - CTRL_NONE = 2'd0, CTRL_LEFT = 2'd1, CTRL_RIGHT = 2'd2. The paddle block must use these same constants.
  - State encoding IDLE / LEFT / RIGHT.
- Sub-module `button_debounce`: sync chain plus debounce counter, one instance per button. Parameters DB_LIMIT and DB_BITS; ports clk, rst, raw, stable.

Test Plan (DB_LIMIT=4, DB_BITS=3, MOVE_DIV=8, DIV_BITS=4, DEADZONE=4):
1. Reset, then hold btn_left=1 steady → btn_state=2'b01 six clocks after the edge; controls=1 exactly on move_tick cycles (every 8 clocks), 0 otherwise.
2. btn_right toggles every 2 clocks for 20 clocks, then settles at 1 → btn_state[1] rises only 6 clocks after the last toggle; no controls=2 before that.
3. Left held, then right also pressed → controls stays 1 on ticks; release left → controls=2 from the next tick.
4. auto_mode=1, paddle_x=300:
   - ball_x=295 → controls=1 on ticks.
   - ball_x=296 and ball_x=304 → controls=0.
   - ball_x=305 → controls=2.
   - ball_x=0 with paddle_x=3 → controls=0 (no underflow).
5. rst asserted for one clock mid-debounce (cnt=2) with a button still held → btn_state=0, controls=0, move_tick=0 next clock; debounce and tick restart from 0.
6. Random stimulus, 10k clocks → controls never equals 3; controls ≠ 0 implies move_tick=1.
